// File: rtl/round_robin_arbiter4_pkg.sv
// Shared definitions for the four-way round-robin arbiter: state encoding,
// default hold limit and hold counter width.
package round_robin_arbiter4_pkg;

  // Arbiter states: no grant, one owner granted, forced dead cycle.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  // Default maximum consecutive grant cycles while another requester waits.
  localparam int HOLD_MAX_DEFAULT = 16;

  // Width of the hold counter; supports hold limits up to 255.
  localparam int CNT_W = 8;

endpackage

// File: rtl/round_robin_arbiter4_rr_pick4.sv
// Rotating-priority scan over four requests: starting at start_i and
// wrapping, the first asserted request wins. Purely combinational.
module rr_pick4
  import round_robin_arbiter4_pkg::*;
(
  input  logic [3:0] req_i,
  input  logic [1:0] start_i,
  output logic       found_o,
  output logic [1:0] winner_o
);

  // Requests rotated so that bit 0 is the highest-priority position.
  logic [3:0] rot;
  logic [1:0] offset;

  for (genvar gi = 0; gi < 4; gi++) begin : g_rot
    assign rot[gi] = req_i[start_i + 2'(gi)];
  end

  // Fixed-priority encode of the rotated vector, then rotate the index back.
  always_comb begin
    found_o = |rot;
    if (rot[0])      offset = 2'd0;
    else if (rot[1]) offset = 2'd1;
    else if (rot[2]) offset = 2'd2;
    else             offset = 2'd3;
    winner_o = start_i + offset;
  end

endmodule

// File: rtl/round_robin_arbiter4.sv
// Four-way round-robin arbiter with a hold-time limit. A granted owner keeps
// the grant while it requests; once it has held for HOLD_MAX cycles and
// someone else is waiting it is preempted. Every hand-off passes through one
// all-zero GAP cycle so the downstream one-hot mux never sees overlap.
module round_robin_arbiter4
  import round_robin_arbiter4_pkg::*;
#(
  parameter int HOLD_MAX = HOLD_MAX_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_request0,
  input  logic       i_request1,
  input  logic       i_request2,
  input  logic       i_request3,
  output logic       o_select0,
  output logic       o_select1,
  output logic       o_select2,
  output logic       o_select3,
  output logic       o_valid,
  output logic [1:0] o_owner,
  output logic       o_preempt
);

  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_MAX);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       last_q, last_d;
  logic [3:0]       sel_q, sel_d;
  logic [1:0]       owner_q, owner_d;
  logic             valid_q, valid_d;
  logic             preempt_q, preempt_d;

  logic [3:0] req;
  logic [1:0] scan_start;
  logic       pick_found;
  logic [1:0] pick_winner;
  logic       owner_req;
  logic       others_req;
  logic       preempt_evt;

  assign req        = {i_request3, i_request2, i_request1, i_request0};
  assign scan_start = last_q + 2'd1;
  assign owner_req  = req[last_q];
  assign others_req = |(req & ~(4'b0001 << last_q));

  rr_pick4 u_pick (
    .req_i    (req),
    .start_i  (scan_start),
    .found_o  (pick_found),
    .winner_o (pick_winner)
  );

  // State and registered outputs; reset drops any grant immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      last_q    <= 2'd3;
      sel_q     <= 4'b0000;
      owner_q   <= 2'd0;
      valid_q   <= 1'b0;
      preempt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      sel_q     <= sel_d;
      owner_q   <= owner_d;
      valid_q   <= valid_d;
      preempt_q <= preempt_d;
    end
  end

  // Next state: GAP behaves like IDLE on its way out, giving a 2-cycle hand-off.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    preempt_evt = 1'b0;
    case (state_q)
      ST_IDLE, ST_GAP: begin
        if (pick_found) begin
          state_d = ST_GRANT;
          cnt_d   = CNT_W'(1);
          last_d  = pick_winner;
        end else begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      ST_GRANT: begin
        if (!owner_req) begin
          // Voluntary release wins over a coincident timeout.
          state_d = ST_GAP;
          cnt_d   = '0;
        end else if ((cnt_q == HOLD_LIM) && others_req) begin
          state_d     = ST_GAP;
          cnt_d       = '0;
          preempt_evt = 1'b1;
        end else if (cnt_q != HOLD_LIM) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs derived from the next state so they are registered with it.
  always_comb begin
    sel_d     = 4'b0000;
    owner_d   = 2'd0;
    valid_d   = 1'b0;
    preempt_d = preempt_evt;
    if (state_d == ST_GRANT) begin
      sel_d   = 4'b0001 << last_d;
      owner_d = last_d;
      valid_d = 1'b1;
    end
  end

  assign o_select0 = sel_q[0];
  assign o_select1 = sel_q[1];
  assign o_select2 = sel_q[2];
  assign o_select3 = sel_q[3];
  assign o_valid   = valid_q;
  assign o_owner   = owner_q;
  assign o_preempt = preempt_q;

endmodule

// File: tb/tb_round_robin_arbiter4.sv
// Bench for round_robin_arbiter4: two instances (HOLD_MAX=4 and 16) share the
// request inputs and are compared every cycle against a behavioural model,
// plus directed checks for the hand-off, timeout and reset scenarios.
module tb_round_robin_arbiter4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;

  logic [3:0] sel_a, sel_b;
  logic       val_a, val_b, pre_a, pre_b;
  logic [1:0] own_a, own_b;

  always #5 clk = ~clk;

  round_robin_arbiter4 #(.HOLD_MAX(4)) dut_a (
    .clk(clk), .rst(rst),
    .i_request0(req[0]), .i_request1(req[1]), .i_request2(req[2]), .i_request3(req[3]),
    .o_select0(sel_a[0]), .o_select1(sel_a[1]), .o_select2(sel_a[2]), .o_select3(sel_a[3]),
    .o_valid(val_a), .o_owner(own_a), .o_preempt(pre_a)
  );

  round_robin_arbiter4 #(.HOLD_MAX(16)) dut_b (
    .clk(clk), .rst(rst),
    .i_request0(req[0]), .i_request1(req[1]), .i_request2(req[2]), .i_request3(req[3]),
    .o_select0(sel_b[0]), .o_select1(sel_b[1]), .o_select2(sel_b[2]), .o_select3(sel_b[3]),
    .o_valid(val_b), .o_owner(own_b), .o_preempt(pre_b)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // Behavioural model per instance: owner index (-1 = nobody), cycles held,
  // most recent owner, and whether this cycle is a timeout revocation.
  int hold_lim [2] = '{4, 16};
  int m_owner  [2];
  int m_cnt    [2];
  int m_last   [2];
  bit m_pre    [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_owner[i] = -1;
      m_cnt[i]   = 0;
      m_last[i]  = 3;
      m_pre[i]   = 1'b0;
    end
  endfunction

  function automatic void model_step(input logic [3:0] r);
    for (int i = 0; i < 2; i++) begin
      m_pre[i] = 1'b0;
      if (m_owner[i] >= 0) begin
        int o;
        bit others;
        o = m_owner[i];
        others = 1'b0;
        for (int k = 0; k < 4; k++) if (k != o && r[k]) others = 1'b1;
        if (!r[o]) begin
          m_owner[i] = -1;
        end else if (m_cnt[i] == hold_lim[i] && others) begin
          m_owner[i] = -1;
          m_pre[i]   = 1'b1;
        end else if (m_cnt[i] < hold_lim[i]) begin
          m_cnt[i] = m_cnt[i] + 1;
        end
      end else if (!m_pre[i]) begin
        // Nobody owns (idle or after a dead cycle): rotate from last owner.
        for (int k = 1; k <= 4; k++) begin
          int c;
          c = (m_last[i] + k) % 4;
          if (m_owner[i] < 0 && r[c]) begin
            m_owner[i] = c;
            m_last[i]  = c;
            m_cnt[i]   = 1;
          end
        end
      end
    end
  endfunction

  task automatic check_models(input string tag);
    for (int i = 0; i < 2; i++) begin
      logic [3:0] s;
      logic       v, p;
      logic [1:0] ow;
      logic [3:0] es;
      s  = (i == 0) ? sel_a : sel_b;
      v  = (i == 0) ? val_a : val_b;
      p  = (i == 0) ? pre_a : pre_b;
      ow = (i == 0) ? own_a : own_b;
      es = (m_owner[i] >= 0) ? (4'b0001 << m_owner[i]) : 4'b0000;
      chk($sformatf("%s.h%0d.select", tag, hold_lim[i]), 32'(s), 32'(es));
      chk($sformatf("%s.h%0d.valid", tag, hold_lim[i]), 32'(v), 32'(m_owner[i] >= 0));
      chk($sformatf("%s.h%0d.owner", tag, hold_lim[i]), 32'(ow),
          32'((m_owner[i] >= 0) ? m_owner[i] : 0));
      chk($sformatf("%s.h%0d.preempt", tag, hold_lim[i]), 32'(p), 32'(m_pre[i]));
      chk($sformatf("%s.h%0d.onehot", tag, hold_lim[i]), 32'($countones(s) <= 1), 32'd1);
    end
  endtask

  // One clock: inputs already set at the negedge, model follows the edge,
  // outputs are sampled on the next falling edge.
  task automatic cycle(input string tag);
    @(posedge clk);
    model_step(req);
    @(negedge clk);
    check_models(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req = 4'b0000;
    model_reset();
    @(negedge clk);
    check_models("reset");
    rst = 1'b0;
  endtask

  initial begin
    int q_own[$];
    int n_valid, n_pre;
    logic prev_v;

    rst = 1'b1;
    req = 4'b0000;
    model_reset();
    #1;
    check_models("reset_t0");

    // Reset release with request 2: granted one cycle later.
    do_reset();
    req = 4'b0100;
    cycle("lat");
    chk("lat.sel2", 32'(sel_a), 32'h4);
    chk("lat.owner2", 32'(own_a), 32'd2);
    chk("lat.valid", 32'(val_a), 32'd1);
    cycle("lat_hold");
    req = 4'b0000;
    cycle("lat_gap");
    cycle("lat_idle");

    // All four requesting with HOLD_MAX=4: 0,1,2,3,0 each for 4 cycles.
    do_reset();
    req = 4'b1111;
    n_valid = 0;
    n_pre   = 0;
    prev_v  = 1'b0;
    for (int c = 0; c < 25; c++) begin
      cycle("rot");
      if (val_a && !prev_v) q_own.push_back(int'(own_a));
      if (val_a) n_valid++;
      if (pre_a) n_pre++;
      prev_v = val_a;
    end
    chk("rot.runs", 32'(q_own.size()), 32'd5);
    if (q_own.size() >= 5) begin
      chk("rot.order0", 32'(q_own[0]), 32'd0);
      chk("rot.order1", 32'(q_own[1]), 32'd1);
      chk("rot.order2", 32'(q_own[2]), 32'd2);
      chk("rot.order3", 32'(q_own[3]), 32'd3);
      chk("rot.order4", 32'(q_own[4]), 32'd0);
    end
    chk("rot.valid_cycles", 32'(n_valid), 32'd20);
    chk("rot.preempts", 32'(n_pre), 32'd5);

    // Owner 1 releases while 3 waits: one dead cycle without preempt.
    do_reset();
    req = 4'b0010;
    cycle("rel");
    req = 4'b1010;
    cycle("rel");
    cycle("rel");
    req = 4'b1000;
    cycle("rel_gap");
    chk("rel.gap_sel", 32'(sel_a), 32'h0);
    chk("rel.gap_pre", 32'(pre_a), 32'd0);
    cycle("rel_next");
    chk("rel.sel3", 32'(sel_a), 32'h8);

    // Single requester for 40 cycles: no rotation, no preempt.
    do_reset();
    req = 4'b0001;
    for (int c = 0; c < 40; c++) begin
      cycle("solo");
      chk("solo.sel0", 32'(sel_b), 32'h1);
      chk("solo.pre", 32'(pre_b), 32'd0);
    end
    req = 4'b0000;
    cycle("solo_end");

    // Release coincident with timeout: plain gap, no preempt pulse.
    do_reset();
    req = 4'b0011;
    for (int c = 0; c < 4; c++) cycle("tie");
    req = 4'b0010;
    cycle("tie_gap");
    chk("tie.gap_sel", 32'(sel_a), 32'h0);
    chk("tie.gap_pre", 32'(pre_a), 32'd0);
    cycle("tie_next");
    chk("tie.sel1", 32'(sel_a), 32'h2);

    // Reset mid-grant of requester 3, then 0 beats 3 after release.
    do_reset();
    req = 4'b1000;
    cycle("mid");
    cycle("mid");
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("mid.async_sel_a", 32'(sel_a), 32'h0);
    chk("mid.async_sel_b", 32'(sel_b), 32'h0);
    chk("mid.async_valid", 32'(val_a), 32'd0);
    req = 4'b1001;
    @(negedge clk);
    check_models("mid_rst");
    rst = 1'b0;
    cycle("mid_rel");
    chk("mid.winner0", 32'(sel_a), 32'h1);
    chk("mid.owner0", 32'(own_b), 32'd0);

    // Randomized persistent requests, each bit toggling occasionally.
    do_reset();
    for (int c = 0; c < 600; c++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(5, 0) == 0) req[b] = ~req[b];
      end
      cycle("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
